// File: rtl/rv_iopmp_bram_arbiter_if.sv
// Bus bundle for the IOPMP entry BRAM arbiter: config port, checker fetch port,
// BRAM port and statistics. The slave modport is the arbiter's view.
interface rv_iopmp_bram_arbiter_if #(
  parameter int unsigned NUMBER_ENTRIES = 8,
  parameter int unsigned BRAM_DWIDTH    = 128
);
  localparam int unsigned AW = $clog2(NUMBER_ENTRIES);

  logic                   cfg_we_i;
  logic                   cfg_en_i;
  logic [AW-1:0]          cfg_addr_i;
  logic [BRAM_DWIDTH-1:0] cfg_din_i;
  logic [BRAM_DWIDTH-1:0] cfg_dout_o;
  logic                   chk_req_i;
  logic [AW-1:0]          chk_addr_i;
  logic                   chk_gnt_o;
  logic                   chk_rvalid_o;
  logic [BRAM_DWIDTH-1:0] chk_rdata_o;
  logic                   chk_flush_o;
  logic                   bram_we_o;
  logic                   bram_en_o;
  logic [AW-1:0]          bram_addr_o;
  logic [BRAM_DWIDTH-1:0] bram_din_o;
  logic [BRAM_DWIDTH-1:0] bram_dout_i;
  logic [31:0]            stat_stall_cnt_o;
  logic [31:0]            stat_gnt_cnt_o;

  modport slave (
    input  cfg_we_i, cfg_en_i, cfg_addr_i, cfg_din_i,
    input  chk_req_i, chk_addr_i, bram_dout_i,
    output cfg_dout_o, chk_gnt_o, chk_rvalid_o, chk_rdata_o, chk_flush_o,
    output bram_we_o, bram_en_o, bram_addr_o, bram_din_o,
    output stat_stall_cnt_o, stat_gnt_cnt_o
  );

  modport master (
    output cfg_we_i, cfg_en_i, cfg_addr_i, cfg_din_i,
    output chk_req_i, chk_addr_i, bram_dout_i,
    input  cfg_dout_o, chk_gnt_o, chk_rvalid_o, chk_rdata_o, chk_flush_o,
    input  bram_we_o, bram_en_o, bram_addr_o, bram_din_o,
    input  stat_stall_cnt_o, stat_gnt_cnt_o
  );
endinterface

// File: rtl/rv_iopmp_bram_arbiter.sv
// Fixed-priority arbiter sharing the single-port IOPMP entry BRAM between the config
// port (always wins) and the checker fetch port. Stall/grant counters: RV_IOPMP_BRAM_ARB_STATS_EN.
module rv_iopmp_bram_arbiter #(
  parameter int unsigned NUMBER_ENTRIES = 8,
  parameter int unsigned BRAM_DWIDTH    = 128
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  rv_iopmp_bram_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(NUMBER_ENTRIES);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CFG  = 2'd1,
    OWN_CHK  = 2'd2
  } own_e;

  own_e                   own_q;
  own_e                   own_next_s;
  logic                   flush_r;
  logic                   gnt_s;
  logic                   bram_en_s;
  logic                   bram_we_s;
  logic [AW-1:0]          bram_addr_s;
  logic [BRAM_DWIDTH-1:0] bram_din_s;
  logic                   rvalid_s;
  logic [BRAM_DWIDTH-1:0] rdata_s;
  logic [BRAM_DWIDTH-1:0] cfg_dout_s;

  // Owner register: who drove the BRAM last cycle, so its read data is steered back.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      own_q <= OWN_IDLE;
    end else begin
      own_q <= own_next_s;
    end
  end

  // Next owner follows the fixed-priority arbitration decision.
  always_comb begin
    own_next_s = OWN_IDLE;
    if (bus.cfg_en_i) begin
      own_next_s = OWN_CFG;
    end else if (bus.chk_req_i) begin
      own_next_s = OWN_CHK;
    end else begin
      own_next_s = OWN_IDLE;
    end
  end

  // BRAM drive and response steering.
  always_comb begin
    gnt_s       = 1'b0;
    bram_en_s   = 1'b0;
    bram_we_s   = 1'b0;
    bram_addr_s = {AW{1'b0}};
    bram_din_s  = {BRAM_DWIDTH{1'b0}};
    rvalid_s    = 1'b0;
    rdata_s     = {BRAM_DWIDTH{1'b0}};
    cfg_dout_s  = {BRAM_DWIDTH{1'b0}};
    if (bus.cfg_en_i) begin
      bram_en_s   = 1'b1;
      bram_we_s   = bus.cfg_we_i;
      bram_addr_s = bus.cfg_addr_i;
      bram_din_s  = bus.cfg_din_i;
    end else if (bus.chk_req_i) begin
      bram_en_s   = 1'b1;
      bram_addr_s = bus.chk_addr_i;
      gnt_s       = 1'b1;
    end else begin
      bram_en_s   = 1'b0;
    end
    case (own_q)
      OWN_CFG: cfg_dout_s = bus.bram_dout_i;
      OWN_CHK: begin
        rvalid_s = 1'b1;
        rdata_s  = bus.bram_dout_i;
      end
      default: begin
        rvalid_s = 1'b0;
      end
    endcase
  end

  // Any config write invalidates entries the checker may already hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_r <= 1'b0;
    end else begin
      flush_r <= bus.cfg_en_i & bus.cfg_we_i;
    end
  end

`ifdef RV_IOPMP_BRAM_ARB_STATS_EN
  logic        stall_s;
  logic [31:0] stall_cnt_r;
  logic [31:0] gnt_cnt_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  assign stall_s = bus.chk_req_i & ~gnt_s;

  // Saturating statistics counters, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_r <= 32'd0;
      gnt_cnt_r   <= 32'd0;
    end else begin
      if (stall_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (gnt_s) begin
        gnt_cnt_r <= sat_inc(gnt_cnt_r);
      end
    end
  end

  assign bus.stat_stall_cnt_o = stall_cnt_r;
  assign bus.stat_gnt_cnt_o   = gnt_cnt_r;
`else
  assign bus.stat_stall_cnt_o = 32'd0;
  assign bus.stat_gnt_cnt_o   = 32'd0;
`endif

  assign bus.chk_gnt_o    = gnt_s;
  assign bus.bram_en_o    = bram_en_s;
  assign bus.bram_we_o    = bram_we_s;
  assign bus.bram_addr_o  = bram_addr_s;
  assign bus.bram_din_o   = bram_din_s;
  assign bus.chk_rvalid_o = rvalid_s;
  assign bus.chk_rdata_o  = rdata_s;
  assign bus.cfg_dout_o   = cfg_dout_s;
  assign bus.chk_flush_o  = flush_r;
endmodule

// File: tb/tb_rv_iopmp_bram_arbiter.sv
// Scoreboard bench for rv_iopmp_bram_arbiter: a BRAM model, a shadow entry table as
// reference, directed scenarios followed by random traffic.
module tb_rv_iopmp_bram_arbiter;
  localparam int NE = 8;
  localparam int DW = 128;
  localparam int AW = $clog2(NE);

  typedef struct {
    int          cyc;
    logic [DW-1:0] data;
  } resp_t;

  logic clk;
  logic rst_ni;
  int   cyc_n;
  int   chk_cnt;
  int   pass_cnt;

  resp_t chk_q[$];
  resp_t cfg_q[$];
  int    flush_q[$];
  logic [DW-1:0] shadow [NE];
  longint exp_stall;
  longint exp_gnt;

  rv_iopmp_bram_arbiter_if #(.NUMBER_ENTRIES(NE), .BRAM_DWIDTH(DW)) bus ();

  rv_iopmp_bram_arbiter #(.NUMBER_ENTRIES(NE), .BRAM_DWIDTH(DW)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Single-port BRAM model, read-first, one cycle latency
  initial begin
    logic [DW-1:0] mem [NE];
    logic [DW-1:0] rd;
    for (int i = 0; i < NE; i++) mem[i] = DW'(i);
    bus.bram_dout_i <= '0;
    forever begin
      @(posedge clk);
      if (bus.bram_en_o === 1'b1) begin
        rd = mem[bus.bram_addr_o];
        if (bus.bram_we_o === 1'b1) mem[bus.bram_addr_o] = bus.bram_din_o;
        bus.bram_dout_i <= rd;
      end
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  function automatic longint sat32(input longint v);
    return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
  endfunction

  function automatic longint stat_exp(input longint v);
`ifdef RV_IOPMP_BRAM_ARB_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Drive one cycle of requests, check arbitration, record expected responses
  task automatic drive(input logic ce, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic cr, input logic [AW-1:0] cra,
                       output logic granted);
    logic          g;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    resp_t         r;
    @(negedge clk);
    bus.cfg_en_i   = ce;
    bus.cfg_we_i   = cw;
    bus.cfg_addr_i = ca;
    bus.cfg_din_i  = cd;
    bus.chk_req_i  = cr;
    bus.chk_addr_i = cra;
    #1;
    g  = !ce && cr;
    ea = ce ? ca : (cr ? cra : AW'(0));
    ed = ce ? cd : DW'(0);
    check("arb_ctrl{gnt,en,we,addr}",
          {bus.chk_gnt_o, bus.bram_en_o, bus.bram_we_o, bus.bram_addr_o},
          {g, ce | cr, ce & cw, ea});
    check("bram_din", bus.bram_din_o, ed);
    if (ce) begin
      r.cyc = cyc_n + 1; r.data = shadow[ca];
      cfg_q.push_back(r);
      if (cw) begin
        shadow[ca] = cd;
        flush_q.push_back(cyc_n + 1);
      end
    end else if (cr) begin
      r.cyc = cyc_n + 1; r.data = shadow[cra];
      chk_q.push_back(r);
    end
    if (ce && cr) exp_stall = sat32(exp_stall + 1);
    if (g) exp_gnt = sat32(exp_gnt + 1);
    granted = g;
  endtask

  task automatic idle(input int n);
    logic g;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, '0, g);
  endtask

  // Monitor: compare registered outputs against the scoreboard every cycle
  initial begin
    logic fe;
    forever begin
      @(posedge clk);
      #1;
      if (rst_ni === 1'b0) begin
        check("reset_state{rvalid,flush}", {bus.chk_rvalid_o, bus.chk_flush_o}, 2'b00);
        check("reset_cnt", {bus.stat_stall_cnt_o, bus.stat_gnt_cnt_o}, 64'd0);
      end else begin
        while (chk_q.size() > 0 && chk_q[0].cyc < cyc_n) begin
          check("chk_resp_lost", 1'b1, 1'b0);
          void'(chk_q.pop_front());
        end
        if (bus.chk_rvalid_o === 1'b1) begin
          if (chk_q.size() > 0 && chk_q[0].cyc == cyc_n) begin
            check("chk_rdata", bus.chk_rdata_o, chk_q[0].data);
            void'(chk_q.pop_front());
          end else begin
            check("chk_rvalid_unexpected", bus.chk_rvalid_o, 1'b0);
          end
        end else if (chk_q.size() > 0 && chk_q[0].cyc == cyc_n) begin
          check("chk_rvalid_missing", bus.chk_rvalid_o, 1'b1);
          void'(chk_q.pop_front());
        end else begin
          check("chk_idle{rvalid,rdata}", {bus.chk_rvalid_o, bus.chk_rdata_o}, '0);
        end
        while (cfg_q.size() > 0 && cfg_q[0].cyc < cyc_n) void'(cfg_q.pop_front());
        if (cfg_q.size() > 0 && cfg_q[0].cyc == cyc_n) begin
          check("cfg_dout", bus.cfg_dout_o, cfg_q[0].data);
          void'(cfg_q.pop_front());
        end else begin
          check("cfg_dout_idle", bus.cfg_dout_o, '0);
        end
        fe = 1'b0;
        while (flush_q.size() > 0 && flush_q[0] <= cyc_n) begin
          fe = (flush_q[0] == cyc_n);
          void'(flush_q.pop_front());
        end
        check("chk_flush", bus.chk_flush_o, fe);
        check("stat_stall_cnt", bus.stat_stall_cnt_o, stat_exp(exp_stall));
        check("stat_gnt_cnt", bus.stat_gnt_cnt_o, stat_exp(exp_gnt));
      end
    end
  end

  initial begin
    logic          g;
    logic          pend;
    logic [AW-1:0] paddr;
    logic          ce, cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    cyc_n = 0; chk_cnt = 0; pass_cnt = 0;
    exp_stall = 0; exp_gnt = 0;
    for (int i = 0; i < NE; i++) shadow[i] = DW'(i);
    bus.cfg_en_i = 1'b0; bus.cfg_we_i = 1'b0; bus.cfg_addr_i = '0; bus.cfg_din_i = '0;
    bus.chk_req_i = 1'b0; bus.chk_addr_i = '0;
    rst_ni = 1'b1;
    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;

    // Idle after reset
    idle(10);

    // Checker burst over every entry
    for (int i = 0; i < NE; i++) drive(1'b0, 1'b0, '0, '0, 1'b1, AW'(i), g);
    idle(1);
    check("burst_gnt_cnt", bus.stat_gnt_cnt_o, stat_exp(8));

    // Collision: config write wins, checker retries next cycle
    drive(1'b1, 1'b1, AW'(3), DW'(128'hA5), 1'b1, AW'(3), g);
    check("collision_gnt", g, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, AW'(3), g);
    idle(2);

    // Stale data: grant on entry 5, then overwrite it
    drive(1'b0, 1'b0, '0, '0, 1'b1, AW'(5), g);
    drive(1'b1, 1'b1, AW'(5), DW'(128'h5A5A_0000_1234), 1'b0, '0, g);
    idle(2);

    // Config read: no flush, no checker response
    drive(1'b1, 1'b0, AW'(2), DW'(128'hDEAD), 1'b0, '0, g);
    idle(2);

    // Random traffic honouring the checker hold-until-grant rule
    pend = 1'b0; paddr = '0;
    for (int n = 0; n < 400; n++) begin
      ce = ($urandom_range(0, 3) == 0);
      cw = $urandom_range(0, 1) == 1;
      ca = AW'($urandom_range(0, NE - 1));
      cd = {$urandom, $urandom, $urandom, $urandom};
      if (!pend) begin
        pend  = ($urandom_range(0, 2) != 0);
        paddr = AW'($urandom_range(0, NE - 1));
      end
      drive(ce, cw, ca, cd, pend, paddr, g);
      if (g) pend = 1'b0;
    end
    idle(3);

    // Reset while a checker read is in flight
    @(negedge clk);
    bus.chk_req_i = 1'b1; bus.chk_addr_i = AW'(1);
    #1;
    check("midrst_gnt", bus.chk_gnt_o, 1'b1);
    #1;
    rst_ni = 1'b0;
    chk_q.delete(); cfg_q.delete(); flush_q.delete();
    exp_stall = 0; exp_gnt = 0;
    bus.chk_req_i = 1'b0; bus.chk_addr_i = '0;
    check("midrst_rvalid", bus.chk_rvalid_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    idle(4);

    check("end_chk_q_empty", 32'(chk_q.size()), 32'd0);
    check("end_flush_q_empty", 32'(flush_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
